// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
//   Front end for a 32-bit combinational ALU. Tagged commands arrive on a
//   valid/ready stream and are queued in a DEPTH-entry FIFO. One command at a
//   time is driven onto the ALU lanes, the result is captured after the lanes
//   have settled, and it is returned with its tag on a valid/ready response
//   stream, strictly in command order.
//
// Ports
//   clk_i, rst_n_i        clock (rising edge), asynchronous active-low reset
//   cmd_valid_i/ready_o   command handshake; ready = FIFO not full
//   cmd_sel_i/a_i/b_i     ALU op code and operands
//   cmd_tag_i             command tag, echoed on the response
//   alu_in1_o/in2_o/sel_o registered lanes to the ALU
//   alu_ans_i             ALU result
//   rsp_valid_o/ready_i   response handshake; data/tag/err held until accepted
//   rsp_data_o/tag_o      captured result and its tag
//   rsp_err_o             op code 3'b110 is illegal: err=1, data=0
//   busy_o                FIFO non-empty or FSM not idle
module alu_cmd_sequencer #(
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 4,
    parameter int SETTLE = 1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [2:0]       cmd_sel_i,
    input  logic [31:0]      cmd_a_i,
    input  logic [31:0]      cmd_b_i,
    input  logic [TAG_W-1:0] cmd_tag_i,
    output logic [31:0]      alu_in1_o,
    output logic [31:0]      alu_in2_o,
    output logic [2:0]       alu_sel_o,
    input  logic [31:0]      alu_ans_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [31:0]      rsp_data_o,
    output logic [TAG_W-1:0] rsp_tag_o,
    output logic             rsp_err_o,
    output logic             busy_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(SETTLE + 1);
    localparam logic [2:0] SEL_ILLEGAL = 3'b110;

    typedef struct packed {
        logic [2:0]       sel;
        logic [31:0]      a;
        logic [31:0]      b;
        logic [TAG_W-1:0] tag;
    } cmd_t;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_RESP} state_e;

    // ---------------- command FIFO ----------------
    cmd_t            mem [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic            full, empty, push, pop;
    cmd_t            cmd_in, head;

    assign full   = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty  = (wr_ptr_q == rd_ptr_q);
    // Ready comes from registered pointers only, so a pop in the same cycle
    // cannot open the door to a push while full.
    assign push   = cmd_valid_i && !full;
    assign cmd_in = '{sel: cmd_sel_i, a: cmd_a_i, b: cmd_b_i, tag: cmd_tag_i};
    assign head   = mem[rd_ptr_q[AW-1:0]];

    // Storage needs no reset: emptiness is defined by the pointers alone.
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr_q[AW-1:0]] <= cmd_in;
    end

    // ---------------- sequencer ----------------
    state_e           state_q, state_d;
    logic [31:0]      in1_q, in1_d, in2_q, in2_d;
    logic [2:0]       sel_q, sel_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [31:0]      data_q, data_d;
    logic [TAG_W-1:0] rtag_q, rtag_d;
    logic             err_q, err_d;

    always_comb begin
        state_d  = state_q;
        in1_d    = in1_q;
        in2_d    = in2_q;
        sel_d    = sel_q;
        tag_d    = tag_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        rtag_d   = rtag_q;
        err_d    = err_q;
        pop      = 1'b0;
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = rd_ptr_q;

        case (state_q)
            S_IDLE: begin
                // Popping loads the lanes directly; they stay put until the
                // next command so idle lanes show the last command issued.
                if (!empty) begin
                    pop      = 1'b1;
                    rd_ptr_d = rd_ptr_q + PW'(1);
                    in1_d    = head.a;
                    in2_d    = head.b;
                    sel_d    = head.sel;
                    tag_d    = head.tag;
                    state_d  = S_LOAD;
                end
            end
            S_LOAD: begin
                if (sel_q == SEL_ILLEGAL) begin
                    data_d  = '0;
                    rtag_d  = tag_q;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // SETTLE settling cycles followed by the capture cycle, which
                // gives an accept-to-response latency of 3+SETTLE.
                if (cnt_q == CW'(SETTLE)) begin
                    data_d  = alu_ans_i;
                    rtag_d  = tag_q;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            in1_q    <= '0;
            in2_q    <= '0;
            sel_q    <= '0;
            tag_q    <= '0;
            cnt_q    <= '0;
            data_q   <= '0;
            rtag_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            in1_q    <= in1_d;
            in2_q    <= in2_d;
            sel_q    <= sel_d;
            tag_q    <= tag_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            rtag_q   <= rtag_d;
            err_q    <= err_d;
        end
    end

    assign cmd_ready_o = !full;
    assign alu_in1_o   = in1_q;
    assign alu_in2_o   = in2_q;
    assign alu_sel_o   = sel_q;
    assign rsp_valid_o = (state_q == S_RESP);
    assign rsp_data_o  = data_q;
    assign rsp_tag_o   = rtag_q;
    assign rsp_err_o   = err_q;
    assign busy_o      = !empty || (state_q != S_IDLE) || pop;

endmodule
